// File: rtl/multiplier_seq_n_bit_v.sv
// Sequential shift-and-add multiplier, unsigned or two's-complement, with
// valid/ready handshakes on operands and product; one partial product per clock.
module multiplier_seq_n_bit_v #(
  parameter int WIDTH = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic               i_signed,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [2*WIDTH-1:0] o_f
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     mag_a, mag_b, abs_a, abs_b;
  logic                 neg;
  logic [2*WIDTH-1:0]   acc, addend, acc_nxt;
  logic [CW-1:0]        count;
  logic                 last;

  // Work on magnitudes; the sign is reapplied once at the end. The most-negative
  // operand maps to 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit value.
  assign abs_a   = (i_signed && i_a[WIDTH-1]) ? (~i_a + 1'b1) : i_a;
  assign abs_b   = (i_signed && i_b[WIDTH-1]) ? (~i_b + 1'b1) : i_b;
  assign addend  = mag_b[count] ? ({{WIDTH{1'b0}}, mag_a} << count) : '0;
  assign acc_nxt = acc + addend;
  assign last    = (count == CW'(WIDTH - 1));

  always_comb begin
    state_nxt = state;
    o_ready   = 1'b0;
    o_valid   = 1'b0;
    unique case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) state_nxt = CALC;
      end
      CALC: if (last) state_nxt = DONE;
      DONE: begin
        o_valid = 1'b1;
        if (i_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      mag_a <= '0;
      mag_b <= '0;
      neg   <= 1'b0;
      acc   <= '0;
      count <= '0;
      o_f   <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: if (i_valid) begin
          mag_a <= abs_a;
          mag_b <= abs_b;
          neg   <= i_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
          acc   <= '0;
          count <= '0;
        end
        CALC: begin
          acc   <= acc_nxt;
          count <= count + 1'b1;
          if (last) o_f <= neg ? (~acc_nxt + 1'b1) : acc_nxt;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/multiplier_seq_n_bit_v.md
# multiplier_seq_n_bit_v

Parametrised, sequential shift-and-add multiplier that generalises the team's 4-bit unsigned array multiplier to any operand width and adds a signed mode. One partial product is accumulated per clock, trading latency for area. A valid/ready handshake is used on both the operand and result sides, so the block drops into the team's streaming datapaths without glue logic.

## Interface
- `WIDTH`, default 4: operand width in bits; legal range 2..32; product width is 2*WIDTH.
- `i_clk`  input  1  clock; all state changes on the rising edge.
- `i_rst`  input  1  reset, synchronous and active-high.
- `i_valid`  input  1  operands on `i_a`, `i_b` and `i_signed` are valid.
- `o_ready`  output  1  block can accept operands (high only in IDLE).
- `i_signed`  input  1  0 = unsigned multiply; 1 = two's-complement multiply.
- `i_a`  input  WIDTH  multiplicand.
- `i_b`  input  WIDTH  multiplier.
- `o_valid`  output  1  `o_f` holds a completed product.
- `i_ready`  input  1  downstream accepts the product.
- `o_f`  output  2*WIDTH  product; low half corresponds to the old `o_fu0`, high half to `o_fu1`.

## Operation
- States: IDLE, CALC, DONE. `o_ready` = (state == IDLE); `o_valid` = (state == DONE).
- IDLE: an operand accept happens at a rising edge where `i_valid & o_ready` is high. On accept:
  - latch the magnitudes |a| and |b| as unsigned WIDTH-bit values (magnitude = operand when `i_signed`=0);
  - latch the result sign `neg` = `i_signed & (a[MSB] ^ b[MSB])`;
  - clear the accumulator (2*WIDTH bits) and the bit counter;
  - go to CALC.
- CALC, one step per cycle:
  - if multiplier bit[count] = 1, add the multiplicand shifted left by count into the accumulator;
  - increment count.
  - The step with count = WIDTH-1 writes `o_f` = `neg` ? two's-complement negation of the accumulator : accumulator, then goes to DONE.
- DONE: `o_f` is stable while `o_valid` is high. On `i_ready` high, go to IDLE. There is no same-cycle re-accept; `o_ready` rises in the following cycle.
- `i_valid` is ignored outside IDLE. Operand inputs are sampled only at the accept edge, so later changes have no effect on the product.
- Arithmetic: all products are exact in 2*WIDTH bits, with no overflow in either mode.
  - Most-negative magnitude: 2^(WIDTH-1) is representable as an unsigned WIDTH-bit value.
  - Largest signed case: (-2^(W-1))^2 = 2^(2W-2), which is below 2^(2W-1)-1.
- `o_f` holds the last product until the next completion. It is never cleared except by reset.

## Timing
- Reset values:
  - state = IDLE, so `o_ready`=1 in the cycle after reset;
  - `o_valid`=0, `o_f`=0, accumulator=0, count=0.
- Latency: accept at edge E. `o_valid` is high after edge E+WIDTH and remains high until the edge where `i_ready`=1.
- Throughput with `i_ready` held high: one product per WIDTH+2 cycles.
- Reset mid-operation, in CALC or DONE: the block returns to IDLE at the reset edge, the in-flight result is discarded, and `o_f` = 0.
- Reset takes priority over a simultaneous accept or result handshake.
- `i_ready` may be high before `o_valid`; it has no effect outside DONE.

## Test plan
- Reset: assert `i_rst` for 2 cycles with `i_valid`=1. Required response: `o_valid`=0, `o_f`=0, `o_ready`=1 after release, and no accept during reset.
- Unsigned, WIDTH=4:
  - 15×15 gives `o_f`=0xE1, with `o_valid` high exactly 4 cycles after the accept edge;
  - 0×9 gives 0x00;
  - exhaustive 256-pair sweep matches `i_a*i_b`.
- Signed, WIDTH=4:
  - -3×5 gives 0xF1 (-15);
  - -8×-8 gives 0x40 (64);
  - 7×-8 gives 0xC8 (-56);
  - exhaustive sweep matches the signed reference model.
- Backpressure: hold `i_ready`=0 for 10 cycles after `o_valid`. Required response: `o_f` stable, `o_ready`=0, and a new `i_valid` with different operands is ignored. Raising `i_ready` returns the block to IDLE next cycle with the original product delivered.
- Mid-operation reset: pulse `i_rst` 2 cycles after the accept of 15×15. Required response: IDLE, `o_f`=0, and `o_valid` never asserted for that operation. A following 3×4 returns 0x0C.
- WIDTH=8 regression: 255×255 gives 0xFE01 with 8-cycle latency; signed -128×-128 gives 0x4000. Random back-to-back traffic with random `i_ready` gaps matches the model with no lost or duplicated results.
